// File: rtl/rd_fifo_arbiter.sv
`timescale 1ns/1ps
// rtl/rd_fifo_arbiter.sv - round-robin arbiter sharing one read-FIFO byte packer among flash channels
module rd_fifo_arbiter #(
   parameter int NUM_CHANNELS     = 4,
   parameter int CHAN_BITS        = 2,
   parameter int ERROR_CODE_WIDTH = 8,
   parameter int MAX_BYTES        = 4096,
   parameter int CNT_WIDTH        = 13
) (
   input  logic                                     i_clk,
   input  logic                                     i_rst,
   input  logic [NUM_CHANNELS-1:0]                  i_req,
   input  logic [8*NUM_CHANNELS-1:0]                i_data,
   input  logic [ERROR_CODE_WIDTH*NUM_CHANNELS-1:0] i_error_code,
   input  logic [NUM_CHANNELS-1:0]                  i_we,
   input  logic [NUM_CHANNELS-1:0]                  i_flush,
   output logic [NUM_CHANNELS-1:0]                  o_full,
   output logic [NUM_CHANNELS-1:0]                  o_gnt,
   output logic [7:0]                               o_pk_data,
   output logic [ERROR_CODE_WIDTH-1:0]              o_pk_error_code,
   output logic                                     o_pk_we,
   output logic                                     o_pk_flush,
   input  logic                                     i_pk_full,
   output logic [CHAN_BITS-1:0]                     o_cur_chan,
   output logic                                     o_overrun
);

   typedef enum logic [1:0] {IDLE, GRANT, DRAIN_HI, DRAIN_LO} state_t;

   state_t                  state_q, state_d;
   logic [NUM_CHANNELS-1:0] gnt_q, gnt_d;
   logic [CHAN_BITS-1:0]    cur_chan_q, cur_chan_d;
   logic [CHAN_BITS-1:0]    ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [CHAN_BITS-1:0]    sel_chan;
   logic                    sel_valid;
   logic                    in_grant, fwd, forced, flush_any;
   int                      idx;

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      sel_valid = 1'b0;
      sel_chan  = '0;
      idx       = 0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         idx = (int'(ptr_q) + i) % NUM_CHANNELS;
         if (!sel_valid && i_req[idx]) begin
            sel_valid = 1'b1;
            sel_chan  = CHAN_BITS'(idx);
         end
      end
   end

   assign in_grant  = (state_q == GRANT);
   assign fwd       = in_grant & i_we[cur_chan_q] & ~i_pk_full;
   assign forced    = fwd & (cnt_q == CNT_WIDTH'(MAX_BYTES - 1)) & ~i_flush[cur_chan_q];
   assign flush_any = in_grant & (i_flush[cur_chan_q] | forced);

   assign o_pk_data       = i_data[8*cur_chan_q +: 8];
   assign o_pk_error_code = i_error_code[ERROR_CODE_WIDTH*cur_chan_q +: ERROR_CODE_WIDTH];
   assign o_pk_we         = fwd;
   assign o_pk_flush      = flush_any;
   assign o_overrun       = forced;
   assign o_gnt           = gnt_q;
   assign o_cur_chan      = cur_chan_q;

   always_comb begin
      o_full = '1;
      if (in_grant) begin
         o_full[cur_chan_q] = i_pk_full;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      cur_chan_d = cur_chan_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               gnt_d      = NUM_CHANNELS'(1) << sel_chan;
               cur_chan_d = sel_chan;
               cnt_d      = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (fwd) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (flush_any) begin
               gnt_d   = '0;
               ptr_d   = (cur_chan_q == CHAN_BITS'(NUM_CHANNELS - 1)) ? '0 : cur_chan_q + 1'b1;
               state_d = DRAIN_HI;
            end
         end
         // Packer raises full while writing its word and drops it once the Read FIFO accepts it.
         DRAIN_HI: begin
            if (i_pk_full) begin
               state_d = DRAIN_LO;
            end
         end
         DRAIN_LO: begin
            if (!i_pk_full) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         cur_chan_q <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         cur_chan_q <= cur_chan_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rd_fifo_arbiter.sv
`timescale 1ns/1ps
// tb/tb_rd_fifo_arbiter.sv - directed self-checking bench for rd_fifo_arbiter
module tb_rd_fifo_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, we, flush;
   logic [31:0] data, ec;
   logic        pk_full;
   logic [3:0]  o_full, o_gnt;
   logic [7:0]  o_pk_data, o_pk_error_code;
   logic        o_pk_we, o_pk_flush, o_overrun;
   logic [1:0]  o_cur_chan;

   int n_cmp = 0;
   int n_err = 0;

   int           we_cnt = 0, flush_cnt = 0, ovr_cnt = 0;
   logic [127:0] word_cap = '0;
   logic [7:0]   err_cap = '0;
   int           we0, fl0, ov0;
   int           exp_seq [5] = '{0, 1, 2, 3, 0};

   rd_fifo_arbiter #(
      .NUM_CHANNELS(4), .CHAN_BITS(2), .ERROR_CODE_WIDTH(8), .MAX_BYTES(20), .CNT_WIDTH(13)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_error_code(ec),
      .i_we(we), .i_flush(flush), .o_full(o_full), .o_gnt(o_gnt),
      .o_pk_data(o_pk_data), .o_pk_error_code(o_pk_error_code), .o_pk_we(o_pk_we),
      .o_pk_flush(o_pk_flush), .i_pk_full(pk_full), .o_cur_chan(o_cur_chan),
      .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;

   // Packer-side observer: collects forwarded bytes and pulse counts.
   always @(negedge clk) begin
      if (o_pk_we) begin
         we_cnt   <= we_cnt + 1;
         word_cap <= {word_cap[119:0], o_pk_data};
      end
      if (o_pk_flush) begin
         flush_cnt <= flush_cnt + 1;
         err_cap   <= o_pk_error_code;
      end
      if (o_overrun) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req = '0; we = '0; flush = '0; data = '0; ec = '0; pk_full = 1'b0;
      tick(); tick();
      rst = 1'b0; #1;
      chk("rst_gnt", o_gnt, 0);
      chk("rst_full", o_full, 4'hF);
      chk("rst_cur", o_cur_chan, 0);
      chk("rst_we", o_pk_we, 0);
      chk("rst_flush", o_pk_flush, 0);
      chk("rst_ovr", o_overrun, 0);

      // Single 16-byte transfer on channel 2
      req = 4'b0100;
      tick(); req = '0; #1;
      chk("t1_gnt", o_gnt, 4'b0100);
      chk("t1_cur", o_cur_chan, 2);
      chk("t1_full", o_full, 4'b1011);
      we0 = we_cnt; fl0 = flush_cnt;
      for (int b = 0; b < 16; b++) begin
         data[23:16] = 8'(b); we = 4'b0100;
         tick();
      end
      we = '0; flush = 4'b0100; ec[23:16] = 8'h5A; #1;
      chk("t1_flush", o_pk_flush, 1);
      chk("t1_we_at_flush", o_pk_we, 0);
      tick(); flush = '0; #1;
      chk("t1_we_cycles", we_cnt - we0, 16);
      chk("t1_flush_cycles", flush_cnt - fl0, 1);
      chk("t1_word", {err_cap, word_cap}, {8'h5A, 128'h000102030405060708090A0B0C0D0E0F});
      chk("t1_drain_gnt", o_gnt, 0);
      req = 4'b0001;
      tick(); #1;
      chk("t1_hi_hold", o_gnt, 0);
      pk_full = 1'b1;
      tick(); #1;
      chk("t1_lo_gnt", o_gnt, 0);
      chk("t1_lo_full", o_full, 4'hF);
      pk_full = 1'b0;
      tick(); #1;
      chk("t1_idle_gnt", o_gnt, 0);
      tick(); #1;
      chk("t1_regrant", o_gnt, 4'b0001);

      // Round robin with all channels requesting, zero-byte transfers
      rst = 1'b1; req = '0;
      tick();
      rst = 1'b0; req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         tick(); #1;
         chk("rr_gnt", o_gnt, 4'b0001 << exp_seq[k]);
         chk("rr_cur", o_cur_chan, exp_seq[k]);
         flush = 4'b0001 << exp_seq[k]; #1;
         chk("rr_flush", o_pk_flush, 1);
         tick(); flush = '0; #1;
         chk("rr_hi_gnt", o_gnt, 0);
         pk_full = 1'b1;
         tick(); #1;
         chk("rr_lo_gnt", o_gnt, 0);
         pk_full = 1'b0;
         tick(); #1;
         chk("rr_idle_gnt", o_gnt, 0);
         if (k == 4) req = '0;
      end

      // Channel 1: stall mid-transfer, then forced flush at 20 bytes
      req = 4'b0010;
      tick(); req = '0; #1;
      chk("t3_gnt", o_gnt, 4'b0010);
      ov0 = ovr_cnt; we0 = we_cnt;
      for (int n = 0; n < 20; n++) begin
         data[15:8] = 8'h80 + 8'(n); we = 4'b0010;
         if (n == 5) begin
            pk_full = 1'b1;
            for (int s = 0; s < 5; s++) begin
               #1;
               chk("t3_stall_full", o_full, 4'hF);
               chk("t3_stall_we", o_pk_we, 0);
               tick();
            end
            pk_full = 1'b0;
         end
         #1;
         chk("t3_full", o_full, 4'b1101);
         chk("t3_ovr", o_overrun, (n == 19));
         chk("t3_flush", o_pk_flush, (n == 19));
         tick();
      end
      we = '0; #1;
      chk("t3_drain_gnt", o_gnt, 0);
      chk("t3_ovr_after", o_overrun, 0);
      chk("t3_ovr_cycles", ovr_cnt - ov0, 1);
      chk("t3_we_cycles", we_cnt - we0, 20);
      chk("t3_tail", word_cap, 128'h8485868788898A8B8C8D8E8F90919293);
      pk_full = 1'b1; tick();
      pk_full = 1'b0; tick();

      // Reset mid-transfer after 7 bytes on channel 2
      req = 4'b0100;
      tick(); req = '0; #1;
      chk("t4_gnt", o_gnt, 4'b0100);
      for (int b = 0; b < 7; b++) begin
         data[23:16] = 8'(b); we = 4'b0100;
         tick();
      end
      rst = 1'b1; we = '0;
      tick();
      rst = 1'b0; #1;
      chk("t4_rst_gnt", o_gnt, 0);
      chk("t4_rst_full", o_full, 4'hF);
      req = 4'b1010;
      tick(); #1;
      chk("t4_gnt_after", o_gnt, 4'b0010);
      chk("t4_cur_after", o_cur_chan, 1);

      // Zero-byte flush then grant passes to channel 3
      we0 = we_cnt;
      flush = 4'b0010; #1;
      chk("t5_flush", o_pk_flush, 1);
      tick(); flush = '0;
      pk_full = 1'b1; tick();
      pk_full = 1'b0; tick();
      tick(); #1;
      chk("t5_next_gnt", o_gnt, 4'b1000);
      chk("t5_no_bytes", we_cnt - we0, 0);
      req = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
